// File: rtl/dac_out_ctrl.sv
// dac_out_ctrl: output stage after the 14-bit sample delay line.
// - Registers the requested delay select and drives it to the delay line.
// - Hides select-switch transients with a fade-out / hold / fade-in envelope.
// - Applies Q1.7 gain (scaled by the envelope) with saturation in a
//   3-stage pipeline. Samples are offset binary in and out (midscale 2000h).
// Ports:
//   clk, rstn      sample clock, async active-low reset
//   sel_req[2:0]   requested delay code
//   gain[7:0]      unsigned Q1.7 gain, 128 = unity
//   data_in        delayed sample, offset binary
//   delay_sel_out  select code driven to the delay line
//   dac_data       DAC sample, offset binary
//   busy           high in every state except RUN (registered)
// Optional build macro SAT_CNT_EN adds:
//   sat_clr        synchronous clear of the saturation counter
//   sat_cnt[15:0]  count of clipped output samples, sticks at FFFFh
`timescale 1ns/1ps
module dac_out_ctrl #(
  parameter int DATA_W    = 14,
  parameter int RAMP_STEP = 4,
  parameter int HOLD_CYC  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [2:0]        sel_req,
  input  logic [7:0]        gain,
  input  logic [DATA_W-1:0] data_in,
  output logic [2:0]        delay_sel_out,
  output logic [DATA_W-1:0] dac_data,
  output logic              busy
`ifdef SAT_CNT_EN
  ,
  input  logic              sat_clr,
  output logic [15:0]       sat_cnt
`endif
);

  localparam int PW    = DATA_W + 9;               // product width
  localparam int CNT_W = $clog2(HOLD_CYC);
  localparam logic [7:0] RAMP_MAX = 8'd128;
  localparam logic [7:0] STEP     = 8'(RAMP_STEP);
  localparam logic signed [PW-1:0] QMAX = PW'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [PW-1:0] QMIN = -QMAX - PW'(1);
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {RUN, FADE_OUT, SWITCH, FADE_IN} state_t;

  state_t           state_q, state_d;
  logic [7:0]       ramp_q, ramp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             fade_step;

  // ---------------- envelope FSM ----------------
  // A mismatch seen in RUN or FADE_IN already takes the first fade-out step
  // on the detecting clock, so a full fade-out spans 32 clocks from the change.
  always_comb begin
    state_d   = state_q;
    ramp_d    = ramp_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    fade_step = 1'b0;
    unique case (state_q)
      RUN: begin
        ramp_d = RAMP_MAX;
        if (sel_req != sel_q) fade_step = 1'b1;
      end
      FADE_IN: begin
        if (sel_req != sel_q) fade_step = 1'b1;
        else if (ramp_q >= RAMP_MAX - STEP) begin
          ramp_d  = RAMP_MAX;
          state_d = RUN;
        end else ramp_d = ramp_q + STEP;
      end
      FADE_OUT: fade_step = 1'b1;
      SWITCH: begin
        ramp_d = '0;
        if (cnt_q == CNT_W'(HOLD_CYC - 1)) state_d = FADE_IN;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = FADE_IN;
    endcase
    if (fade_step) begin
      if (ramp_q <= STEP) begin
        // target sampled only here, on SWITCH entry
        ramp_d  = '0;
        state_d = SWITCH;
        sel_d   = sel_req;
        cnt_d   = '0;
      end else begin
        ramp_d  = ramp_q - STEP;
        state_d = FADE_OUT;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= FADE_IN;
      ramp_q  <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      busy    <= 1'b1;
    end else begin
      state_q <= state_d;
      ramp_q  <= ramp_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      busy    <= (state_d != RUN);
    end
  end

  assign delay_sel_out = sel_q;

  // ---------------- gain datapath ----------------
  logic [7:0]              gain_r;
  logic [8:0]              eff_gain, e1;
  logic [15:0]             gprod;
  logic [6:0]              unused_gprod_lo;
  logic signed [DATA_W-1:0] s1;
  logic signed [PW-1:0]    prod, p2, q_full;
  logic [DATA_W-1:0]       q_sat;

  assign gprod           = gain_r * ramp_q;
  assign unused_gprod_lo = gprod[6:0];
  assign prod            = s1 * $signed({1'b0, e1});
  assign q_full          = p2 >>> 7;

  always_comb begin
    q_sat = q_full[DATA_W-1:0];
    if (q_full > QMAX)      q_sat = QMAX[DATA_W-1:0];
    else if (q_full < QMIN) q_sat = QMIN[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gain_r   <= '0;
      eff_gain <= '0;
      s1       <= '0;
      e1       <= '0;
      p2       <= '0;
      dac_data <= MID;
    end else begin
      gain_r   <= gain;
      eff_gain <= gprod[15:7];
      s1       <= {~data_in[DATA_W-1], data_in[DATA_W-2:0]};
      e1       <= eff_gain;
      p2       <= prod;
      dac_data <= {~q_sat[DATA_W-1], q_sat[DATA_W-2:0]};
    end
  end

`ifdef SAT_CNT_EN
  logic clip;
  assign clip = (q_full > QMAX) || (q_full < QMIN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                              sat_cnt <= '0;
    else if (sat_clr)                       sat_cnt <= '0;
    else if (clip && (sat_cnt != 16'hFFFF)) sat_cnt <= sat_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_dac_out_ctrl.sv
`timescale 1ns/1ps
module tb_dac_out_ctrl;
  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  sel_req;
  logic [7:0]  gain;
  logic [13:0] data_in;
  logic [2:0]  delay_sel_out;
  logic [13:0] dac_data;
  logic        busy;
`ifdef SAT_CNT_EN
  logic        sat_clr;
  logic [15:0] sat_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  dac_out_ctrl dut (
    .clk(clk), .rstn(rstn), .sel_req(sel_req), .gain(gain), .data_in(data_in),
    .delay_sel_out(delay_sel_out), .dac_data(dac_data), .busy(busy)
`ifdef SAT_CNT_EN
    , .sat_clr(sat_clr), .sat_cnt(sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: offset binary in, envelope-scaled Q1.7 gain, floor, clip.
  function automatic logic [13:0] ref_dac(int d, int g, int r);
    int e, s, q;
    e = (g * r) / 128;
    s = d - 8192;
    q = (s * e) >>> 7;
    if (q > 8191)  q = 8191;
    if (q < -8192) q = -8192;
    return 14'(q + 8192);
  endfunction

  // Envelope level m clocks after a select change seen at level lvl:
  // step down 4/clk, hold 32 clocks at zero, step up 4/clk to 128.
  function automatic int env(int m, int lvl);
    int nd;
    nd = lvl / 4;
    if (m <= 0)       return lvl;
    if (m <= nd)      return lvl - 4 * m;
    if (m <= nd + 32) return 0;
    if (m <= nd + 64) return 4 * (m - nd - 32);
    return 128;
  endfunction

  task automatic wait_soft_start(input string name);
    int cnt;
    cnt = 0;
    while (busy && cnt < 200) begin tick; cnt++; end
    n_chk++;
    if (cnt !== 32) begin
      n_fail++;
      $display("FAIL %s: busy high for %0d clk, expected 32", name, cnt);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; sel_req = 3'd0; gain = 8'd128; data_in = 14'h2000;
    repeat (3) tick;
    n_chk++; if (dac_data !== 14'h2000) begin n_fail++; $display("FAIL rst_dac: got %h exp 2000", dac_data); end
    n_chk++; if (delay_sel_out !== 3'd0) begin n_fail++; $display("FAIL rst_sel: got %0d exp 0", delay_sel_out); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b exp 1", busy); end
    #2 rstn = 1'b1;
    wait_soft_start("soft_start");
    n_chk++; if (delay_sel_out !== 3'd0) begin n_fail++; $display("FAIL start_sel: got %0d exp 0", delay_sel_out); end
  endtask

  task automatic test_latency;
    data_in = 14'h2000;
    repeat (8) tick;
    data_in = 14'h3000;
    tick; tick;
    n_chk++; if (dac_data !== 14'h2000) begin n_fail++; $display("FAIL lat_early: got %h exp 2000", dac_data); end
    tick;
    n_chk++; if (dac_data !== 14'h3000) begin n_fail++; $display("FAIL lat_3clk: got %h exp 3000", dac_data); end
  endtask

  task automatic test_gain_fixed;
    gain = 8'd64; data_in = 14'h3000; repeat (8) tick;
    n_chk++; if (dac_data !== 14'h2800) begin n_fail++; $display("FAIL gain_half: got %h exp 2800", dac_data); end
    gain = 8'd255; data_in = 14'h3FFF; repeat (8) tick;
    n_chk++; if (dac_data !== 14'h3FFF) begin n_fail++; $display("FAIL clip_hi: got %h exp 3fff", dac_data); end
    data_in = 14'h0000; repeat (4) tick;
    n_chk++; if (dac_data !== 14'h0000) begin n_fail++; $display("FAIL clip_lo: got %h exp 0000", dac_data); end
  endtask

  task automatic test_gain_random;
    int q[$];
    int g, d, e;
    for (int i = 0; i < 6; i++) begin
      g = (i == 0) ? 0 : (i == 1) ? 255 : int'($urandom_range(255));
      gain = 8'(g);
      repeat (8) tick;
      q.delete();
      for (int k = 0; k < 24; k++) begin
        d = int'($urandom_range(16383));
        data_in = 14'(d);
        q.push_back(d);
        tick;
        if (q.size() == 3) begin
          e = q.pop_front();
          n_chk++;
          if (dac_data !== ref_dac(e, g, 128)) begin
            n_fail++;
            $display("FAIL gain_rand g=%0d d=%h: got %h exp %h", g, e, dac_data, ref_dac(e, g, 128));
          end
        end
      end
    end
  endtask

  // Runs a select change at j=0 (and optionally a second at j=kint) while
  // checking every output sample against the envelope model.
  task automatic run_switch(input string name, input logic [2:0] s0, input logic [2:0] old_sel,
                            input int kint, input logic [2:0] s1v, input int nj,
                            input int k_lat, input logic [2:0] lat_sel, input int k_idle);
    int d[300];
    int g, r;
    g = int'($urandom_range(255));
    gain = 8'(g);
    repeat (8) tick;
    for (int j = 0; j <= nj; j++) begin
      if (j >= 4) begin
        r = (kint > 0 && j - 4 >= kint) ? env(j - 4 - kint, env(kint, 128)) : env(j - 4, 128);
        n_chk++;
        if (dac_data !== ref_dac(d[j-3], g, r)) begin
          n_fail++;
          $display("FAIL %s_dac j=%0d ramp=%0d: got %h exp %h", name, j, r, dac_data, ref_dac(d[j-3], g, r));
        end
      end
      if (j == 0) begin n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle: busy %b exp 0", name, busy); end end
      if (j == 1) begin n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy_rise: busy %b exp 1", name, busy); end end
      if (j == k_lat - 1) begin n_chk++; if (delay_sel_out === lat_sel && lat_sel !== old_sel) begin n_fail++; $display("FAIL %s_sel_early: got %0d before switch", name, delay_sel_out); end end
      if (j == k_lat) begin n_chk++; if (delay_sel_out !== lat_sel) begin n_fail++; $display("FAIL %s_sel: got %0d exp %0d", name, delay_sel_out, lat_sel); end end
      if (j == k_idle - 1) begin n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy_hold: busy %b exp 1", name, busy); end end
      if (j == k_idle) begin n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_fall: busy %b exp 0", name, busy); end end
      if (j == 0) sel_req = s0;
      if (kint > 0 && j == kint) sel_req = s1v;
      d[j] = int'($urandom_range(16383));
      data_in = 14'(d[j]);
      tick;
    end
  endtask

  task automatic test_switch;
    run_switch("switch", 3'd3, 3'd0, 0, 3'd0, 100, 32, 3'd3, 96);
  endtask

  task automatic test_back_to_back;
    // 3 -> 6, then 6 -> 5 during fade-in at ramp 64
    run_switch("reswitch", 3'd6, 3'd3, 80, 3'd5, 170, 96, 3'd5, 160);
    n_chk++; if (delay_sel_out !== 3'd5) begin n_fail++; $display("FAIL reswitch_final: got %0d exp 5", delay_sel_out); end
  endtask

  task automatic test_reset_mid;
    gain = 8'd128;
    sel_req = 3'd2;
    repeat (10) tick;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_fading: busy %b exp 1", busy); end
    #2 rstn = 1'b0;
    #1;
    n_chk++; if (dac_data !== 14'h2000) begin n_fail++; $display("FAIL mid_rst_dac: got %h exp 2000", dac_data); end
    n_chk++; if (delay_sel_out !== 3'd0) begin n_fail++; $display("FAIL mid_rst_sel: got %0d exp 0", delay_sel_out); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_rst_busy: got %b exp 1", busy); end
    tick;
    sel_req = 3'd0;
    #2 rstn = 1'b1;
    wait_soft_start("mid_soft_start");
    data_in = 14'h3000;
    repeat (6) tick;
    n_chk++; if (dac_data !== 14'h3000) begin n_fail++; $display("FAIL mid_unity: got %h exp 3000", dac_data); end
  endtask

`ifdef SAT_CNT_EN
  task automatic test_sat_cnt;
    gain = 8'd255; data_in = 14'h2000; sat_clr = 1'b1;
    repeat (8) tick;
    sat_clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      data_in = (i % 2 == 0) ? 14'h3FFF : 14'h0000;
      tick;
    end
    data_in = 14'h2100;
    repeat (6) tick;
    n_chk++; if (sat_cnt !== 16'd10) begin n_fail++; $display("FAIL sat_cnt10: got %0d exp 10", sat_cnt); end
    data_in = 14'h3FFF;
    repeat (4) tick;
    sat_clr = 1'b1;
    tick;
    sat_clr = 1'b0;
    n_chk++; if (sat_cnt !== 16'd0) begin n_fail++; $display("FAIL sat_clr_wins: got %0d exp 0", sat_cnt); end
    tick;
    n_chk++; if (sat_cnt !== 16'd1) begin n_fail++; $display("FAIL sat_after_clr: got %0d exp 1", sat_cnt); end
  endtask
`endif

  initial begin
`ifdef SAT_CNT_EN
    sat_clr = 1'b0;
`endif
    test_reset;
    test_latency;
    test_gain_fixed;
    test_gain_random;
    test_switch;
    test_back_to_back;
    test_reset_mid;
`ifdef SAT_CNT_EN
    test_sat_cnt;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
